// File: rtl/counter_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : counter_sequencer
// Description : Sequences a 4-bit counter datapath through one or more
//               clear/count runs of a requested length.
// Revision    : 1.0  initial release
// ============================================================================
module counter_sequencer #(
    parameter int WIDTH  = 4,
    parameter int RUNS_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  target,
    input  logic [RUNS_W-1:0] runs,
    input  logic              abort,
    input  logic [WIDTH-1:0]  q,
    output logic              cnt_rst,
    output logic              cnt_en,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              err,
    output logic [RUNS_W-1:0] run_idx
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_target_m1;
    logic [RUNS_W-1:0] r_last_idx;
    logic [RUNS_W-1:0] r_run_idx;
    logic              r_cnt_rst;
    logic              r_cnt_en;
    logic              r_busy;
    logic              r_done;
    logic              r_aborted;
    logic              r_err;

    logic              w_run_end;
    logic              w_last_run;

    // The run ends on the edge that takes the counter from target-1 to target.
    assign w_run_end  = r_cnt_en && (q == r_target_m1);
    assign w_last_run = (r_run_idx == r_last_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_target_m1 <= '0;
            r_last_idx  <= '0;
            r_run_idx   <= '0;
            r_cnt_rst   <= 1'b1;
            r_cnt_en    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_err     <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_cnt_rst <= 1'b1;
                    r_cnt_en  <= 1'b0;
                    r_busy    <= 1'b0;
                    if (start) begin
                        if (target != '0) begin
                            r_target_m1 <= target - 1'b1;
                            r_last_idx  <= (runs == '0) ? '0 : runs - 1'b1;
                            r_run_idx   <= '0;
                            r_state     <= ST_CLEAR;
                            r_busy      <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end

                ST_CLEAR: begin
                    if (abort) begin
                        r_state   <= ST_IDLE;
                        r_cnt_rst <= 1'b1;
                        r_cnt_en  <= 1'b0;
                        r_busy    <= 1'b0;
                        r_aborted <= 1'b1;
                    end else begin
                        r_state   <= ST_RUN;
                        r_cnt_rst <= 1'b0;
                        r_cnt_en  <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end

                ST_RUN: begin
                    if (abort) begin
                        r_state   <= ST_IDLE;
                        r_cnt_rst <= 1'b1;
                        r_cnt_en  <= 1'b0;
                        r_busy    <= 1'b0;
                        r_aborted <= 1'b1;
                    end else if (w_run_end) begin
                        r_cnt_en <= 1'b0;
                        if (w_last_run) begin
                            r_state   <= ST_DONE;
                            r_cnt_rst <= 1'b0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                        end else begin
                            r_state   <= ST_CLEAR;
                            r_cnt_rst <= 1'b1;
                            r_busy    <= 1'b1;
                            r_run_idx <= r_run_idx + 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    // Counter is left un-reset here so the host can read the final count.
                    r_state   <= ST_IDLE;
                    r_cnt_rst <= 1'b1;
                    r_cnt_en  <= 1'b0;
                    r_busy    <= 1'b0;
                end

                default: begin
                    r_state   <= ST_IDLE;
                    r_cnt_rst <= 1'b1;
                    r_cnt_en  <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign cnt_rst = r_cnt_rst;
    assign cnt_en  = r_cnt_en;
    assign busy    = r_busy;
    assign done    = r_done;
    assign aborted = r_aborted;
    assign err     = r_err;
    assign run_idx = r_run_idx;

endmodule
`default_nettype wire

// File: tb/tb_counter_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_sequencer
// Description : Bench for counter_sequencer with a counter datapath stand-in.
// Revision    : 1.0  initial release
// ============================================================================
module tb_counter_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] target;
    logic [3:0] runs;
    logic       abort;
    logic [3:0] q;
    logic       cnt_rst;
    logic       cnt_en;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       err;
    logic [3:0] run_idx;

    int vectors;
    int miscompares;

    logic [13:0] obs;
    assign obs = {cnt_rst, cnt_en, busy, done, aborted, err, run_idx, q};

    localparam logic [13:0] c_mask_all  = 14'h3FFF;
    localparam logic [13:0] c_mask_noix = 14'h3F0F;
    localparam logic [13:0] c_idle      = {6'b100000, 4'd0, 4'd0};
    localparam logic [13:0] c_aborted   = {6'b100010, 4'd0, 4'd0};
    localparam logic [13:0] c_err       = {6'b100001, 4'd0, 4'd0};

    counter_sequencer #(.WIDTH(4), .RUNS_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .target  (target),
        .runs    (runs),
        .abort   (abort),
        .q       (q),
        .cnt_rst (cnt_rst),
        .cnt_en  (cnt_en),
        .busy    (busy),
        .done    (done),
        .aborted (aborted),
        .err     (err),
        .run_idx (run_idx)
    );

    // Counter datapath with asynchronous clear.
    always_ff @(posedge clk or posedge cnt_rst) begin
        if (cnt_rst) q <= '0;
        else if (cnt_en) q <= q + 1'b1;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs in the cycle after edge E0+j of a sequence (t, r).
    function automatic logic [13:0] expect_at(input int t, input int r, input int j);
        int rr;
        int n;
        int ph;
        int ri;
        rr = (r == 0) ? 1 : r;
        n  = rr * (t + 1);
        if (j < n) begin
            ph = j % (t + 1);
            ri = j / (t + 1);
            if (ph == 0) return {6'b101000, 4'(ri), 4'd0};
            else         return {6'b011000, 4'(ri), 4'(ph - 1)};
        end else if (j == n) begin
            return {6'b000100, 4'(rr - 1), 4'(t)};
        end
        return c_idle;
    endfunction

    function automatic int seq_len(input int t, input int r);
        return ((r == 0) ? 1 : r) * (t + 1);
    endfunction

    task automatic test_reset();
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (obs !== c_idle) begin
                miscompares++;
                $display("FAIL reset_hold got=%b exp=%b", obs, c_idle);
            end
        end
        rst = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            vectors++;
            if (obs !== c_idle) begin
                miscompares++;
                $display("FAIL reset_idle j=%0d got=%b exp=%b", j, obs, c_idle);
            end
        end
    endtask

    task automatic test_sequence(input int t, input int r, input bit spurious,
                                 input bit abort_with_start, input bit abort_in_done);
        int n;
        logic [13:0] m;
        logic [13:0] e;
        n = seq_len(t, r);
        @(negedge clk);
        start  = 1'b1;
        target = 4'(t);
        runs   = 4'(r);
        abort  = abort_with_start;
        for (int j = 0; j <= n + 1; j++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            e = expect_at(t, r, j);
            m = (j > n) ? c_mask_noix : c_mask_all;
            vectors++;
            if ((obs & m) !== (e & m)) begin
                miscompares++;
                $display("FAIL sequence t=%0d r=%0d j=%0d got=%b exp=%b", t, r, j, obs, e);
            end
            if (spurious && j < n - 1 && $urandom_range(0, 2) == 0) begin
                start  = 1'b1;
                target = 4'($urandom_range(1, 15));
                runs   = 4'($urandom_range(0, 15));
            end
            if (abort_in_done && j == n) abort = 1'b1;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_err();
        @(negedge clk);
        start  = 1'b1;
        target = 4'd0;
        runs   = 4'($urandom_range(0, 15));
        abort  = 1'($urandom_range(0, 1));
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        vectors++;
        if ((obs & c_mask_noix) !== c_err) begin
            miscompares++;
            $display("FAIL err_pulse got=%b exp=%b", obs, c_err);
        end
        @(negedge clk);
        vectors++;
        if ((obs & c_mask_noix) !== c_idle) begin
            miscompares++;
            $display("FAIL err_clear got=%b exp=%b", obs, c_idle);
        end
    endtask

    task automatic test_abort(input int t, input int r, input int k, input bit restart);
        int t2;
        int n2;
        logic [13:0] e;
        logic [13:0] m;
        t2 = int'($urandom_range(1, 6));
        @(negedge clk);
        start  = 1'b1;
        target = 4'(t);
        runs   = 4'(r);
        for (int j = 0; j <= k; j++) begin
            @(negedge clk);
            start = 1'b0;
            e = expect_at(t, r, j);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL abort_pre t=%0d k=%0d j=%0d got=%b exp=%b", t, k, j, obs, e);
            end
        end
        abort = 1'b1;
        if (restart) begin
            start  = 1'b1;
            target = 4'(t2);
            runs   = 4'd1;
        end
        @(negedge clk);
        abort = 1'b0;
        vectors++;
        if ((obs & c_mask_noix) !== c_aborted) begin
            miscompares++;
            $display("FAIL abort_pulse t=%0d k=%0d got=%b exp=%b", t, k, obs, c_aborted);
        end
        if (restart) begin
            n2 = seq_len(t2, 1);
            for (int j = 0; j <= n2 + 1; j++) begin
                @(negedge clk);
                start = 1'b0;
                e = expect_at(t2, 1, j);
                m = (j > n2) ? c_mask_noix : c_mask_all;
                vectors++;
                if ((obs & m) !== (e & m)) begin
                    miscompares++;
                    $display("FAIL abort_restart t2=%0d j=%0d got=%b exp=%b", t2, j, obs, e);
                end
            end
        end else begin
            for (int j = 0; j < seq_len(t, r) + 4; j++) begin
                @(negedge clk);
                vectors++;
                if ((obs & c_mask_noix) !== c_idle) begin
                    miscompares++;
                    $display("FAIL abort_quiet j=%0d got=%b exp=%b", j, obs, c_idle);
                end
            end
        end
    endtask

    task automatic test_reset_mid_run(input int t, input int k);
        logic [13:0] e;
        @(negedge clk);
        start  = 1'b1;
        target = 4'(t);
        runs   = 4'd1;
        for (int j = 0; j <= k; j++) begin
            @(negedge clk);
            start = 1'b0;
            e = expect_at(t, 1, j);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL rstmid_pre j=%0d got=%b exp=%b", j, obs, e);
            end
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (obs !== c_idle) begin
            miscompares++;
            $display("FAIL rstmid_async got=%b exp=%b", obs, c_idle);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < t + 4; j++) begin
            @(negedge clk);
            vectors++;
            if (obs !== c_idle) begin
                miscompares++;
                $display("FAIL rstmid_after j=%0d got=%b exp=%b", j, obs, c_idle);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            test_sequence(int'($urandom_range(1, 15)), int'($urandom_range(0, 3)),
                          1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst    = 1'b1;
        start  = 1'b0;
        target = '0;
        runs   = '0;
        abort  = 1'b0;

        test_reset();
        test_sequence(5, 1, 1'b0, 1'b0, 1'b0);
        test_sequence(3, 4, 1'b0, 1'b0, 1'b0);
        test_err();
        test_sequence(15, 0, 1'b0, 1'b1, 1'b0);
        test_abort(10, 2, 4, 1'b0);
        test_abort(10, 2, 4, 1'b1);
        test_abort(4, 3, 0, 1'b0);
        test_abort(4, 3, 5, 1'b0);
        test_sequence(1, 3, 1'b1, 1'b0, 1'b1);
        test_reset_mid_run(8, 5);
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
